move_scheduler: RTL and testbench
=================================

// Module: move_scheduler
// PURPOSE
// - Sequences all piece-motion requests for the Tetris playfield datapath. It merges the gravity timer,
//   PS/2 keyboard moves and lock events into one valid/ready command channel toward the collision-check/board-update datapath.
// - Sits between the keyboard decoder and the game board logic; owns the gravity and key-repeat timing.
// PARAMETERS
// - GRAV_W      25       gravity counter width; one gravity tick every 2**GRAV_W cycles
// - REPEAT_DLY  8388608  cycles between auto-repeats of a held key; also the first-repeat delay
// PORTS
// - i_clk        in   1  clock
// - i_rst_n      in   1  reset, asynchronous, active-low
// - i_key        in   8  PS/2 scancode currently held; 8'h00 = none
// - i_pause      in   1  freeze gravity and stop issuing new commands
// - o_cmd_valid  out  1  command valid
// - o_cmd        out  3  cmd_e: NONE, LEFT, RIGHT, ROT, SOFT, GRAV, DROP
// - i_cmd_ready  in   1  datapath accepts command
// - i_cmd_done   in   1  one-cycle pulse: the accepted command has been evaluated
// - i_cmd_ok     in   1  qualified by i_cmd_done: 1 = move applied, 0 = blocked
// - o_lock_req   out  1  request to lock the piece and spawn the next one; held until i_lock_done
// - i_lock_done  in   1  one-cycle pulse: lock/spawn complete
// - o_busy       out  1  state != IDLE
// BEHAVIOUR
// - Reset values: o_cmd_valid=0, o_cmd=NONE, o_lock_req=0, o_busy=0, all counters=0, pend flags=0, state=IDLE.
// - Async reset mid-command abandons the command. A later i_cmd_done or i_lock_done is ignored in IDLE.
// - Gravity counter: GRAV_W bits, increments every cycle unless i_pause=1 or the state is LOCK.
//   - A tick fires when the counter is all-ones; the counter then wraps to 0.
//   - A tick sets grav_pend. Multiple ticks collapse into one pend.
// - Key events map scancodes: 8'h6b->LEFT, 8'h74->RIGHT, 8'h75->ROT, 8'h72->SOFT. Any other code is ignored.
//   - key_pend is set on a new code (i_key differs from the previous cycle and is valid).
//   - key_pend is also set every REPEAT_DLY cycles while the same code is held.
//   - Releasing the key (or changing it) restarts the repeat counter.
// - FSM:
//   - IDLE:
//     - i_pause=1 stays in IDLE.
//     - grav_pend -> ISSUE(GRAV). Gravity has priority over keys on the same cycle.
//     - Otherwise key_pend -> ISSUE(key command).
//     - The chosen pend flag clears on entry to ISSUE.
//   - ISSUE:
//     - o_cmd_valid=1 with o_cmd stable until i_cmd_ready=1.
//     - Transfer occurs on a cycle with valid&ready; then go to WAIT. o_cmd_valid drops the next cycle.
//   - WAIT:
//     - On i_cmd_done:
//       - ok=1 -> IDLE. A SOFT with ok=1 also clears the gravity counter to 0.
//       - ok=0 with GRAV, SOFT or DROP -> LOCK.
//       - ok=0 with LEFT, RIGHT or ROT -> IDLE, no other effect.
//   - LOCK:
//     - o_lock_req=1 until i_lock_done. Then clear grav_pend, key_pend and the gravity counter -> IDLE.
//     - A held key resumes repeating REPEAT_DLY cycles after lock_done.
// - Simultaneous events:
//   - A tick or key event during ISSUE, WAIT or LOCK sets the pend flag. Pends set during LOCK are discarded on exit.
//   - If i_cmd_done and i_cmd_ready arrive together in ISSUE, only the ready is honoured. Done is counted only in WAIT.
// - Minimum command latency: tick -> IDLE -> ISSUE. o_cmd_valid is high 2 cycles after the tick.
// CONFIGURATION
// - HARD_DROP_EN defined:
//   - Scancode 8'h29 (space, new press only, no repeat) issues DROP.
//   - The scheduler re-issues DROP back-to-back (WAIT ok=1 -> ISSUE) until ok=0, then LOCK.
//   - Gravity ticks during a drop are pended and dropped at lock.
// - HARD_DROP_EN undefined: 8'h29 is ignored; the DROP encoding is never emitted.
// STRUCTURE
// - tetris_pkg: cmd_e enum, FSM state enum, scancode localparams (KEY_UP/DOWN/LEFT/RIGHT/SPACE).
// - Sub-module key_repeat: scancode in -> one-cycle event plus cmd_e.
//   - Owns the previous-code register and the $clog2(REPEAT_DLY)-bit repeat counter.
//   - Its counter is cleared by the scheduler at lock_done.
// TESTING (GRAV_W=6, REPEAT_DLY=16 unless stated)
// - Idle, i_cmd_ready=1, done/ok=1 returned 1 cycle after ready: GRAV issued every 64 cycles, first at cycle 65 after reset.
// - i_key=8'h74 for 40 cycles: RIGHT at press, then at +16 and +32 (3 commands). Release: no further RIGHT.
// - Tick and i_key=8'h6b new in the same cycle: GRAV issued first, LEFT next after done. Neither lost.
// - GRAV returns ok=0: o_lock_req=1 until i_lock_done. Held key 8'h72 emits no SOFT during LOCK; first SOFT 16 cycles after done.
// - i_cmd_ready held 0 for 10 cycles: o_cmd_valid stays 1, o_cmd constant. Async reset mid-WAIT: outputs return to reset values immediately.
// - HARD_DROP_EN: space press, ok=1 x4 then ok=0: exactly 5 DROP transfers then lock. Without macro: 8'h29 gives no command.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types for the Tetris motion scheduler: command/state encodings and PS/2 scancodes.
// HARD_DROP_EN maps the space key to the DROP command.
package tetris_pkg;

  localparam int unsigned CMD_W = 3;
  localparam int unsigned KEY_W = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE  = 3'd0,
    CMD_LEFT  = 3'd1,
    CMD_RIGHT = 3'd2,
    CMD_ROT   = 3'd3,
    CMD_SOFT  = 3'd4,
    CMD_GRAV  = 3'd5,
    CMD_DROP  = 3'd6
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LOCK  = 2'd3
  } state_e;

  localparam logic [KEY_W-1:0] KEY_UP    = 8'h75;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 8'h72;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 8'h6b;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 8'h74;
  localparam logic [KEY_W-1:0] KEY_SPACE = 8'h29;

  // Scancode to motion command; unmapped codes give CMD_NONE.
  function automatic cmd_e key_to_cmd(input logic [KEY_W-1:0] code);
    cmd_e cmd;
    case (code)
      KEY_LEFT:  cmd = CMD_LEFT;
      KEY_RIGHT: cmd = CMD_RIGHT;
      KEY_UP:    cmd = CMD_ROT;
      KEY_DOWN:  cmd = CMD_SOFT;
`ifdef HARD_DROP_EN
      KEY_SPACE: cmd = CMD_DROP;
`endif
      default:   cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Turns the held PS/2 scancode into one-cycle key events: on a new press and
// every REPEAT_DLY cycles while the same code stays held (DROP never repeats).
module key_repeat
  import tetris_pkg::*;
#(
  parameter int unsigned REPEAT_DLY = 8388608
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [KEY_W-1:0] key,
  input  logic             cnt_clr,
  output logic             ev_c,
  output logic [CMD_W-1:0] cmd_c
);

  localparam int unsigned CNT_W = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;

  logic [KEY_W-1:0] prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  cmd_e             cmd;
  logic             valid;
  logic             is_new;
  logic             rpt_hit;

  assign cmd     = key_to_cmd(key);
  assign cmd_c   = cmd;
  assign valid   = (cmd != CMD_NONE);
  assign is_new  = (key != prev_q);
  assign rpt_hit = (cnt_q == CNT_W'(REPEAT_DLY - 1));

  // Repeat counter restarts on any change, release, hit or external clear.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    ev_c  = 1'b0;
    if (is_new || !valid || cnt_clr || rpt_hit) begin
      cnt_d = '0;
    end
    if (valid && is_new) begin
      ev_c = 1'b1;
    end else if (valid && rpt_hit && (cmd != CMD_DROP)) begin
      ev_c = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= key;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Merges gravity ticks, keyboard moves and lock handshakes into one valid/ready
// command channel. Define HARD_DROP_EN to enable the repeating space-bar DROP.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int unsigned GRAV_W     = 25,
  parameter int unsigned REPEAT_DLY = 8388608
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [KEY_W-1:0] i_key,
  input  logic             i_pause,
  output logic             o_cmd_valid,
  output logic [CMD_W-1:0] o_cmd,
  input  logic             i_cmd_ready,
  input  logic             i_cmd_done,
  input  logic             i_cmd_ok,
  output logic             o_lock_req,
  input  logic             i_lock_done,
  output logic             o_busy
);

  state_e            state_q, state_d;
  cmd_e              cmd_q, cmd_d;
  cmd_e              key_cmd_q, key_cmd_d;
  logic [GRAV_W-1:0] grav_cnt_q, grav_cnt_d;
  logic              grav_pend_q, grav_pend_d;
  logic              key_pend_q, key_pend_d;
  logic              rpt_clr;
  logic              grav_run;
  logic              tick;
  logic              key_ev;
  logic [CMD_W-1:0]  key_cmd_raw;

  key_repeat #(
    .REPEAT_DLY (REPEAT_DLY)
  ) u_key_repeat (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .key     (i_key),
    .cnt_clr (rpt_clr),
    .ev_c    (key_ev),
    .cmd_c   (key_cmd_raw)
  );

  assign grav_run = !i_pause && (state_q != ST_LOCK);
  assign tick     = grav_run && (&grav_cnt_q);
  assign o_cmd    = cmd_q;

  // Next state, pend flags and counters; new events win over a pend being consumed.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    grav_cnt_d  = grav_run ? grav_cnt_q + GRAV_W'(1) : grav_cnt_q;
    grav_pend_d = grav_pend_q || tick;
    key_pend_d  = key_pend_q || key_ev;
    key_cmd_d   = key_ev ? cmd_e'(key_cmd_raw) : key_cmd_q;
    rpt_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!i_pause) begin
          if (grav_pend_q) begin
            state_d     = ST_ISSUE;
            cmd_d       = CMD_GRAV;
            grav_pend_d = tick;
          end else if (key_pend_q) begin
            state_d    = ST_ISSUE;
            cmd_d      = key_cmd_q;
            key_pend_d = key_ev;
          end
        end
      end
      ST_ISSUE: begin
        if (i_cmd_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_cmd_done) begin
          if (i_cmd_ok) begin
            state_d = ST_IDLE;
            if (cmd_q == CMD_SOFT) begin
              grav_cnt_d = '0;
            end
`ifdef HARD_DROP_EN
            if (cmd_q == CMD_DROP) begin
              state_d = ST_ISSUE;
            end
`endif
          end else if (cmd_q inside {CMD_GRAV, CMD_SOFT, CMD_DROP}) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOCK: begin
        if (i_lock_done) begin
          state_d     = ST_IDLE;
          grav_pend_d = 1'b0;
          key_pend_d  = 1'b0;
          grav_cnt_d  = '0;
          rpt_clr     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_NONE;
      key_cmd_q   <= CMD_NONE;
      grav_cnt_q  <= '0;
      grav_pend_q <= 1'b0;
      key_pend_q  <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_lock_req  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      key_cmd_q   <= key_cmd_d;
      grav_cnt_q  <= grav_cnt_d;
      grav_pend_q <= grav_pend_d;
      key_pend_q  <= key_pend_d;
      o_cmd_valid <= (state_d == ST_ISSUE);
      o_lock_req  <= (state_d == ST_LOCK);
      o_busy      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler (GRAV_W=6, REPEAT_DLY=16): expected
// commands with their transfer cycle are queued; a monitor pops on each transfer.
module tb_move_scheduler;

  localparam int C_NONE  = 0;
  localparam int C_LEFT  = 1;
  localparam int C_RIGHT = 2;
  localparam int C_SOFT  = 4;
  localparam int C_GRAV  = 5;
  localparam int C_DROP  = 6;

  typedef struct {
    int cmd;
    int cyc;
  } exp_t;

  logic       i_clk;
  logic       i_rst_n;
  logic [7:0] i_key;
  logic       i_pause;
  logic       o_cmd_valid;
  logic [2:0] o_cmd;
  logic       i_cmd_ready;
  logic       i_cmd_done;
  logic       i_cmd_ok;
  logic       o_lock_req;
  logic       i_lock_done;
  logic       o_busy;

  int   checks;
  int   errors;
  int   cyc;
  exp_t exp_q[$];
  bit   ok_q[$];
  bit   prev_xfer;

  move_scheduler #(
    .GRAV_W     (6),
    .REPEAT_DLY (16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_key       (i_key),
    .i_pause     (i_pause),
    .o_cmd_valid (o_cmd_valid),
    .o_cmd       (o_cmd),
    .i_cmd_ready (i_cmd_ready),
    .i_cmd_done  (i_cmd_done),
    .i_cmd_ok    (i_cmd_ok),
    .o_lock_req  (o_lock_req),
    .i_lock_done (i_lock_done),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Cycle index: number of rising edges since reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_cmd(input int c, input int cy);
    exp_t e;
    e.cmd = c;
    e.cyc = cy;
    exp_q.push_back(e);
  endtask

  task automatic at_edge(input int n);
    while (cyc < n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic at_sample(input int n);
    do @(negedge i_clk); while (cyc < n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(o_cmd_valid), 0);
    chk({tag, "_cmd"},   int'(o_cmd), C_NONE);
    chk({tag, "_lock"},  int'(o_lock_req), 0);
    chk({tag, "_busy"},  int'(o_busy), 0);
  endtask

  task automatic do_reset();
    i_rst_n     = 1'b0;
    i_key       = 8'h00;
    i_pause     = 1'b0;
    i_cmd_ready = 1'b1;
    i_lock_done = 1'b0;
    ok_q.delete();
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic end_test(input string name, input int n);
    at_sample(n);
    chk({name, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: pops one expectation per valid&ready transfer.
  initial begin
    prev_xfer = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        prev_xfer = 1'b0;
      end else begin
        if (prev_xfer) chk("valid_drop", int'(o_cmd_valid), 0);
        prev_xfer = o_cmd_valid && i_cmd_ready;
        if (prev_xfer) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd at cyc %0d: got cmd %0d, expected none", cyc, o_cmd);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("xfer_cmd", int'(o_cmd), e.cmd);
            chk("xfer_cyc", cyc, e.cyc);
          end
        end
      end
    end
  end

  // Datapath model: done pulse one cycle after each transfer, ok taken from ok_q (default 1).
  initial begin
    i_cmd_done = 1'b0;
    i_cmd_ok   = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_cmd_valid && i_cmd_ready) begin
        @(posedge i_clk);
        #1;
        i_cmd_done = 1'b1;
        i_cmd_ok   = (ok_q.size() > 0) ? ok_q.pop_front() : 1'b1;
        @(posedge i_clk);
        #1;
        i_cmd_done = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    i_rst_n = 1'b0;

    // Gravity only: first GRAV at 65, then every 64 cycles.
    do_reset();
    expect_cmd(C_GRAV, 65);
    expect_cmd(C_GRAV, 129);
    expect_cmd(C_GRAV, 193);
    end_test("grav", 200);

    // RIGHT held 40 cycles: press, +16, +32; nothing after release.
    do_reset();
    expect_cmd(C_RIGHT, 7);
    expect_cmd(C_RIGHT, 23);
    expect_cmd(C_RIGHT, 39);
    expect_cmd(C_GRAV, 65);
    at_edge(5);
    i_key = 8'h74;
    at_edge(45);
    i_key = 8'h00;
    end_test("repeat", 100);

    // Tick and new LEFT on the same edge: GRAV first, then LEFT.
    do_reset();
    expect_cmd(C_GRAV, 65);
    expect_cmd(C_LEFT, 68);
    at_edge(63);
    i_key = 8'h6b;
    at_edge(70);
    i_key = 8'h00;
    end_test("collide", 100);

    // GRAV blocked -> LOCK; held SOFT key resumes 16 cycles after lock_done.
    do_reset();
    ok_q.push_back(1'b0);
    expect_cmd(C_GRAV, 65);
    expect_cmd(C_SOFT, 98);
    expect_cmd(C_GRAV, 165);
    at_edge(66);
    i_key = 8'h72;
    at_sample(67);
    chk("lock_req_set", int'(o_lock_req), 1);
    chk("lock_busy", int'(o_busy), 1);
    at_sample(79);
    chk("lock_req_held", int'(o_lock_req), 1);
    chk("lock_no_valid", int'(o_cmd_valid), 0);
    at_edge(80);
    i_lock_done = 1'b1;
    at_edge(81);
    i_lock_done = 1'b0;
    at_sample(81);
    chk("lock_req_clr", int'(o_lock_req), 0);
    chk("lock_idle", int'(o_busy), 0);
    at_edge(100);
    i_key = 8'h00;
    end_test("lock", 170);

    // Ready stalled 10 cycles, then async reset in WAIT.
    do_reset();
    i_cmd_ready = 1'b0;
    expect_cmd(C_GRAV, 75);
    for (int c = 65; c <= 74; c++) begin
      at_sample(c);
      chk("stall_valid", int'(o_cmd_valid), 1);
      chk("stall_cmd", int'(o_cmd), C_GRAV);
    end
    at_edge(75);
    i_cmd_ready = 1'b1;
    at_edge(76);
    chk("wait_busy", int'(o_busy), 1);
    chk("wait_valid", int'(o_cmd_valid), 0);
    chk("xfer_seen", exp_q.size(), 0);
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midwait");
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    at_edge(2);
    i_cmd_done = 1'b1;
    i_cmd_ok   = 1'b0;
    at_edge(3);
    i_cmd_done = 1'b0;
    at_sample(4);
    chk("stray_done_lock", int'(o_lock_req), 0);
    chk("stray_done_busy", int'(o_busy), 0);
    end_test("stall", 10);

    // Space bar: DROP chain with ok x4 then blocked, or ignored without the feature.
    do_reset();
`ifdef HARD_DROP_EN
    ok_q.push_back(1'b1);
    ok_q.push_back(1'b1);
    ok_q.push_back(1'b1);
    ok_q.push_back(1'b1);
    ok_q.push_back(1'b0);
    expect_cmd(C_DROP, 7);
    expect_cmd(C_DROP, 9);
    expect_cmd(C_DROP, 11);
    expect_cmd(C_DROP, 13);
    expect_cmd(C_DROP, 15);
    expect_cmd(C_GRAV, 90);
    at_edge(5);
    i_key = 8'h29;
    at_edge(10);
    i_key = 8'h00;
    at_sample(17);
    chk("drop_lock", int'(o_lock_req), 1);
    at_edge(24);
    i_lock_done = 1'b1;
    at_edge(25);
    i_lock_done = 1'b0;
    end_test("drop", 100);
`else
    expect_cmd(C_GRAV, 65);
    at_edge(5);
    i_key = 8'h29;
    at_sample(30);
    chk("space_ignored", int'(o_busy), 0);
    end_test("space", 70);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
